// File: rtl/bitwise_op_arbiter.sv
// Round-robin arbiter that shares one bitwise logic unit (OR/AND/XOR/NOR) among NREQ
// requesters; each accepted operation yields one tagged response held until taken.
module bitwise_op_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [WIDTH*NREQ-1:0]  req_a,
  input  logic [WIDTH*NREQ-1:0]  req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IdW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   id_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, data_q;

  logic             found;
  logic [IdW-1:0]   winner;
  int unsigned      idx, win_idx;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             grant;

  function automatic logic [WIDTH-1:0] bit_op(input logic [1:0]       op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'b00: return a | b;
      2'b01: return a & b;
      2'b10: return a ^ b;
      2'b11: return ~(a | b);
    endcase
  endfunction

  // Scan ptr, ptr+1, ... with wrap; first valid requester wins.
  always_comb begin
    found   = 1'b0;
    idx     = 0;
    win_idx = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = k + ptr_q;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[IdW'(idx)]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    winner = IdW'(win_idx);
    ptr_d  = (win_idx == NREQ - 1) ? '0 : IdW'(win_idx + 1);
  end

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == i) begin
        op_sel = req_op[2*i +: 2];
        a_sel  = req_a[WIDTH*i +: WIDTH];
        b_sel  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  assign grant = (state_q == StIdle) && found;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (found) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q  <= '0;
      id_q   <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
    end else begin
      if (grant) begin
        ptr_q <= ptr_d;
        id_q  <= winner;
        op_q  <= op_sel;
        a_q   <= a_sel;
        b_q   <= b_sel;
      end
      if (state_q == StExec) data_q <= bit_op(op_q, a_q, b_q);
    end
  end

  // req_ready is combinational, so it is gated by reset to stay low while held in reset.
  always_comb begin
    req_ready = '0;
    if (reset_n && grant) req_ready[winner] = 1'b1;
    rsp_valid = (state_q == StResp);
    busy      = (state_q != StIdle);
    rsp_id    = id_q;
    rsp_data  = data_q;
  end

endmodule

// File: tb/tb_bitwise_op_arbiter.sv
// Randomized and directed bench for bitwise_op_arbiter against a transaction-level model.
module tb_bitwise_op_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid, req_ready;
  logic [7:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_data;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: phase counts where the current transaction is (0 none, 1 computing, 2 waiting).
  int       m_phase = 0;
  int       m_ptr   = 0;
  int       m_id    = 0;
  logic [3:0] m_data = '0;

  always #5 clk = ~clk;

  bitwise_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] ref_op(input int op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      0:       return a | b;
      1:       return a & b;
      2:       return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // One clock cycle: drive, check against model, then advance model to the next edge.
  task automatic drive_cycle(input logic [3:0] v, input logic [7:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic rr);
    logic [3:0] exp_rdy;
    int         win;
    @(negedge clk);
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
    exp_rdy = '0;
    win     = -1;
    if (m_phase == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && v[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
    end
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("rsp_valid", rsp_valid, m_phase == 2);
    check_eq("busy", busy, m_phase != 0);
    if (m_phase == 2) begin
      check_eq("rsp_id", rsp_id, m_id);
      check_eq("rsp_data", rsp_data, m_data);
    end
    if (m_phase == 0 && win >= 0) begin
      m_id    = win;
      m_data  = ref_op((op >> (2 * win)) & 3, (a >> (4 * win)) & 4'hF, (b >> (4 * win)) & 4'hF);
      m_ptr   = (win + 1) % NREQ;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 && rr) begin
      m_phase = 0;
    end
  endtask

  logic [3:0] ops_exp [4];
  int         order   [5];

  initial begin
    ops_exp = '{4'b1110, 4'b1000, 4'b0110, 4'b0001};
    order   = '{2, 3, 0, 1, 2};
    reset_n   = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #3;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single request from 2: OR of 1010 and 0101.
    drive_cycle(4'b0100, 8'h00, 16'h0A00, 16'h0500, 1'b0);
    check_eq("t1_grant", req_ready, 4'b0100);
    drive_cycle(4'b0000, 8'h00, 16'h0, 16'h0, 1'b0);
    check_eq("t1_exec_valid", rsp_valid, 0);
    drive_cycle(4'b0000, 8'h00, 16'h0, 16'h0, 1'b0);
    check_eq("t1_valid", rsp_valid, 1);
    check_eq("t1_id", rsp_id, 2);
    check_eq("t1_data", rsp_data, 4'b1111);
    drive_cycle(4'b0000, 8'h00, 16'h0, 16'h0, 1'b1);

    // ptr=3 with requesters 3 and 1 valid: 3 first (wrapping ptr), then 1.
    drive_cycle(4'b1010, 8'h00, 16'h0, 16'h0, 1'b1);
    check_eq("t5_grant3", req_ready, 4'b1000);
    drive_cycle(4'b1010, 8'h00, 16'h0, 16'h0, 1'b1);
    drive_cycle(4'b1010, 8'h00, 16'h0, 16'h0, 1'b1);
    drive_cycle(4'b1010, 8'h00, 16'h0, 16'h0, 1'b1);
    check_eq("t5_grant1", req_ready, 4'b0010);
    drive_cycle(4'b0000, 8'h00, 16'h0, 16'h0, 1'b1);
    drive_cycle(4'b0000, 8'h00, 16'h0, 16'h0, 1'b1);

    // All valid, ptr=2: strict rotation, one grant every 3 cycles.
    for (int i = 0; i < 15; i++) begin
      drive_cycle(4'b1111, 8'hE4, 16'h1234, 16'h5678, 1'b1);
      if (i % 3 == 0) check_eq("t2_order", req_ready, 4'b0001 << order[i / 3]);
      else check_eq("t2_gap", req_ready, 0);
    end

    // Each op on requester 0 with a=1100, b=1010.
    for (int o = 0; o < 4; o++) begin
      drive_cycle(4'b0001, 8'(o), 16'h000C, 16'h000A, 1'b1);
      drive_cycle(4'b0000, 8'h00, 16'h0, 16'h0, 1'b1);
      drive_cycle(4'b0000, 8'h00, 16'h0, 16'h0, 1'b1);
      check_eq("t3_op", rsp_data, ops_exp[o]);
    end

    // Consumer stalls 5 cycles while other requesters wait.
    drive_cycle(4'b0001, 8'h02, 16'h000C, 16'h000A, 1'b0);
    drive_cycle(4'b1111, 8'h00, 16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(4'b1111, 8'h00, 16'hFFFF, 16'hFFFF, 1'b0);
      check_eq("t4_busy", busy, 1);
      check_eq("t4_ready", req_ready, 0);
      check_eq("t4_data", rsp_data, 4'b0110);
      check_eq("t4_id", rsp_id, 0);
    end
    drive_cycle(4'b0000, 8'h00, 16'h0, 16'h0, 1'b1);
    drive_cycle(4'b0000, 8'h00, 16'h0, 16'h0, 1'b0);
    check_eq("t4_idle", busy, 0);

    // Reset asserted asynchronously during EXEC.
    drive_cycle(4'b0100, 8'h30, 16'h0F00, 16'h0300, 1'b0);
    @(posedge clk);
    #2;
    req_valid = 4'b0110;
    reset_n   = 1'b0;
    #1;
    check_eq("t6_req_ready", req_ready, 0);
    check_eq("t6_rsp_valid", rsp_valid, 0);
    check_eq("t6_rsp_id", rsp_id, 0);
    check_eq("t6_rsp_data", rsp_data, 0);
    check_eq("t6_busy", busy, 0);
    m_phase = 0;
    m_ptr   = 0;
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    drive_cycle(4'b0110, 8'h00, 16'h0, 16'h0, 1'b0);
    check_eq("t6_grant1", req_ready, 4'b0010);

    for (int i = 0; i < 400; i++) begin
      drive_cycle(4'($urandom), 8'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
